// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subf_ser_if.sv
// Operand/result bundle for the bit-serial subtractor.
// V exists only with GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN.
interface gf180mcu_fd_sc_mcu7t5v0__subf_ser_if #(
  parameter int W = 8
);
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BI;
  logic         READY;
  logic         DONE;
  logic [W-1:0] D;
  logic         BO;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
  logic         V;

  modport master (
    output START, A, B, BI,
    input  READY, DONE, D, BO, V
  );
  modport slave (
    input  START, A, B, BI,
    output READY, DONE, D, BO, V
  );
`else
  modport master (
    output START, A, B, BI,
    input  READY, DONE, D, BO
  );
  modport slave (
    input  START, A, B, BI,
    output READY, DONE, D, BO
  );
`endif
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subf_ser.sv
// Bit-serial LSB-first W-bit subtractor D = A - B - BI.
// Overflow output V via GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN.
module gf180mcu_fd_sc_mcu7t5v0__subf_ser #(
  parameter int W = 8
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu7t5v0__subf_ser_if.slave bus
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  d_q, d_d;
  logic          br_q, br_d;
  logic          bo_q, bo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          d_bit;
  logic          b_bit;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
  logic          v_q, v_d;
`endif

  // One full-subtractor slice on the current LSBs.
  assign d_bit = sa_q[0] ^ sb_q[0] ^ br_q;
  assign b_bit = (~sa_q[0] & sb_q[0])
               | (~(sa_q[0] ^ sb_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    d_d     = d_q;
    br_d    = br_q;
    bo_d    = bo_q;
    cnt_d   = cnt_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
    v_d     = v_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          sa_d    = bus.A;
          sb_d    = bus.B;
          br_d    = bus.BI;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d  = {1'b0, sa_q[W-1:1]};
        sb_d  = {1'b0, sb_q[W-1:1]};
        br_d  = b_bit;
        res_d = {d_bit, res_q[W-1:1]};
        if (cnt_q == LAST) begin
          d_d     = {d_bit, res_q[W-1:1]};
          bo_d    = b_bit;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
          // br_q is the borrow into the MSB slice here.
          v_d     = br_q ^ b_bit;
`endif
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      cnt_q   <= cnt_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign bus.READY = (state_q == IDLE);
  assign bus.DONE  = (state_q == FIN);
  assign bus.D     = d_q;
  assign bus.BO    = bo_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
  assign bus.V     = v_q;
`endif
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__subf_ser.sv
// Self-checking bench for the bit-serial subtractor.
// Random and directed operands against an integer model.
module tb_gf180mcu_fd_sc_mcu7t5v0__subf_ser;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errs = 0;
  int   checks = 0;

  logic [W-1:0] exp_d = '0;
  logic         exp_bo = 1'b0;
  logic         exp_v = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__subf_ser_if #(.W(W)) bus ();

  gf180mcu_fd_sc_mcu7t5v0__subf_ser #(.W(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Plain signed/unsigned arithmetic reference.
  task automatic model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic bi
  );
    int ud;
    int sd;
    logic [31:0] t;
    ud = int'(a) - int'(b) - int'(bi);
    t = 32'(ud);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
    exp_d  = t[W-1:0];
    exp_bo = (ud < 0);
    exp_v  = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
  endtask

  task automatic run_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic bi,
    input string nm
  );
    logic [W-1:0] old_d;
    int n;
    n = 0;
    while (bus.READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (bus.READY !== 1'b1) begin
      errs++;
      $display("FAIL %s ready_timeout got=%b want=1", nm, bus.READY);
    end
    old_d = exp_d;
    bus.A = a;
    bus.B = b;
    bus.BI = bi;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    bus.BI = 1'($urandom);
    model(a, b, bi);
    for (int k = 1; k < W; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.DONE !== 1'b0 || bus.READY !== 1'b0
          || bus.D !== old_d) begin
        errs++;
        $display("FAIL %s run_k%0d done=%b rdy=%b d=%h want 0 0 %h",
                 nm, k, bus.DONE, bus.READY, bus.D, old_d);
      end
    end
    @(negedge CLK);
    checks++;
    if (bus.DONE !== 1'b1 || bus.READY !== 1'b0
        || bus.D !== exp_d || bus.BO !== exp_bo) begin
      errs++;
      $display("FAIL %s done done=%b rdy=%b d=%h bo=%b want 1 0 %h %b",
               nm, bus.DONE, bus.READY, bus.D, bus.BO, exp_d, exp_bo);
    end
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
    checks++;
    if (bus.V !== exp_v) begin
      errs++;
      $display("FAIL %s v got=%b want=%b", nm, bus.V, exp_v);
    end
`endif
    @(negedge CLK);
    checks++;
    if (bus.DONE !== 1'b0 || bus.READY !== 1'b1
        || bus.D !== exp_d || bus.BO !== exp_bo) begin
      errs++;
      $display("FAIL %s after done=%b rdy=%b d=%h bo=%b want 0 1 %h %b",
               nm, bus.DONE, bus.READY, bus.D, bus.BO, exp_d, exp_bo);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.START = 1'b1;
    bus.A = 8'hAA;
    bus.B = 8'h55;
    bus.BI = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.READY !== 1'b1 || bus.DONE !== 1'b0
        || bus.D !== '0 || bus.BO !== 1'b0) begin
      errs++;
      $display("FAIL reset rdy=%b done=%b d=%h bo=%b want 1 0 00 0",
               bus.READY, bus.DONE, bus.D, bus.BO);
    end
    bus.START = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.READY !== 1'b1 || bus.DONE !== 1'b0) begin
      errs++;
      $display("FAIL idle_hold rdy=%b done=%b want 1 0",
               bus.READY, bus.DONE);
    end
  endtask

  task automatic test_directed();
    run_op(8'h5A, 8'h1C, 1'b0, "vec_5a_1c");
    run_op(8'h00, 8'h01, 1'b0, "vec_00_01");
    run_op(8'h80, 8'h01, 1'b0, "vec_80_01");
    run_op(8'h10, 8'h10, 1'b1, "vec_10_10_bi");
    run_op(8'hFF, 8'hFF, 1'b1, "vec_ff_ff_bi");
    run_op(8'h7F, 8'hFF, 1'b0, "vec_7f_ff");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_ignore_start();
    int pulses;
    bus.A = 8'h05;
    bus.B = 8'h03;
    bus.BI = 1'b0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    model(8'h05, 8'h03, 1'b0);
    pulses = 0;
    for (int k = 1; k <= W + 4; k++) begin
      bus.START = (k == 3);
      bus.A = 8'hFF;
      bus.B = 8'h00;
      @(negedge CLK);
      bus.START = 1'b0;
      if (bus.DONE === 1'b1) begin
        pulses++;
        checks++;
        if (bus.D !== exp_d || bus.BO !== exp_bo) begin
          errs++;
          $display("FAIL ignore_start d=%h bo=%b want %h %b",
                   bus.D, bus.BO, exp_d, exp_bo);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errs++;
      $display("FAIL ignore_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_mid_reset();
    bus.A = 8'h40;
    bus.B = 8'h01;
    bus.BI = 1'b0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    exp_d = '0;
    exp_bo = 1'b0;
    checks++;
    if (bus.READY !== 1'b1 || bus.DONE !== 1'b0
        || bus.D !== '0 || bus.BO !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset rdy=%b done=%b d=%h bo=%b want 1 0 00 0",
               bus.READY, bus.DONE, bus.D, bus.BO);
    end
`ifdef GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
    checks++;
    if (bus.V !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_v got=%b want=0", bus.V);
    end
`endif
    run_op(8'h09, 8'h04, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    int t;
    int first;
    int second;
    first = -1;
    second = -1;
    bus.A = 8'h33;
    bus.B = 8'h44;
    bus.BI = 1'b1;
    model(8'h33, 8'h44, 1'b1);
    bus.START = 1'b1;
    for (t = 0; t < 3 * W + 6; t++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1) begin
        if (first < 0) first = t;
        else if (second < 0) second = t;
      end
    end
    bus.START = 1'b0;
    checks++;
    if (first < 0 || second - first != W + 2) begin
      errs++;
      $display("FAIL back_to_back gap got=%0d want=%0d",
               second - first, W + 2);
    end
    checks++;
    if (bus.D !== exp_d || bus.BO !== exp_bo) begin
      errs++;
      $display("FAIL back_to_back d=%h bo=%b want %h %b",
               bus.D, bus.BO, exp_d, exp_bo);
    end
    repeat (W + 4) @(negedge CLK);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.BI = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__subf_ser.md
Name: gf180mcu_fd_sc_mcu7t5v0__subf_ser

Overview:
- Bit-serial, LSB-first W-bit subtractor: D = A - B - BI, with borrow-out BO.
- Built around one full-subtractor slice and a borrow flop. It is the inverse-direction companion to the full-adder cell.
- Used in area-constrained MCU datapaths where a W-bit ripple subtractor is too large.
- Operands are loaded in parallel via a start/ready handshake; result is presented in parallel with a one-cycle DONE pulse.

Parameters:
- W, 8, operand/result width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; accepted only on a rising CLK edge where READY=1.
- A  input  W  minuend; sampled on the accepting edge.
- B  input  W  subtrahend; sampled on the accepting edge.
- BI  input  1  borrow-in; sampled on the accepting edge.
- READY  output  1  high in IDLE only.
- DONE  output  1  single-cycle pulse; result valid.
- D  output  W  difference; held from DONE until the next accepted START.
- BO  output  1  borrow-out of the MSB; held like D.

Behaviour:
- Reset (RST=1 at a rising edge):
  - State goes to IDLE; READY=1, DONE=0, D=0, BO=0.
  - Internal shift registers, borrow flop and bit counter clear.
  - RST has priority over every other input, including in mid-operation; any partial result is discarded.
- States: IDLE, RUN, FIN.
- IDLE:
  - READY=1.
  - On START=1: load A and B into shift registers SA and SB, borrow flop BR<=BI, counter CNT<=0, go to RUN.
  - START=0 keeps the block in IDLE.
- RUN (READY=0), once per edge:
  - d = SA[0] ^ SB[0] ^ BR.
  - b = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & BR).
  - d shifts into the result register at the MSB end (shift right).
  - SA and SB shift right; BR<=b; CNT<=CNT+1.
  - On the edge where CNT==W-1: D<=final result, BO<=b, DONE<=1, go to FIN.
- FIN:
  - DONE=1 for exactly this one cycle; READY=0.
  - Next edge: DONE<=0, go to IDLE.
- Timing:
  - DONE is visible after the W-th rising edge following the accepting edge.
  - Back-to-back throughput is one operation per W+2 cycles.
- START while READY=0 (RUN or FIN) is ignored; no queuing; in-flight operands are unaffected.
- A, B and BI may change freely after the accepting edge.
- D and BO change only on the DONE edge or on reset; they do not update during RUN.
- Arithmetic is modulo 2^W. BO=1 iff A < B + BI as unsigned values.
- CNT width is clog2(W). CNT never wraps inside RUN because the state transition occurs at W-1.

Optional Feature:
- Macro: GF180MCU_FD_SC_MCU7T5V0__SUBF_SER_OVF_EN
- Defined:
  - Extra output port V (output, 1 bit): signed two's-complement overflow of A - B - BI.
  - V = (borrow into MSB) XOR (borrow out of MSB), captured on the DONE edge.
  - V is held like D and reset to 0.
- Undefined:
  - Port V does not exist; no overflow logic is synthesised.
  - All other behaviour is identical.

Test Plan (W=8):
- A=0x5A, B=0x1C, BI=0, START in IDLE -> DONE after the 8th edge; D=0x3E, BO=0, READY returns to 1 the following cycle.
- A=0x00, B=0x01, BI=0 -> D=0xFF, BO=1; V=0 when the macro is defined.
- A=0x80, B=0x01, BI=0 with macro defined -> D=0x7F, BO=0, V=1.
- A=0x10, B=0x10, BI=1 -> D=0xFF, BO=1, V=0.
- Start A=0x05, B=0x03; pulse START with A=0xFF, B=0x00 at edge 3 of RUN -> second request ignored; D=0x02, BO=0; exactly one DONE pulse.
- Start A=0x40, B=0x01; assert RST at edge 4 of RUN -> next cycle READY=1, DONE=0, D=0x00, BO=0. A new op A=0x09, B=0x04 -> D=0x05, BO=0.
